pwm_divider_multi: RTL and testbench

Multi-channel programmable frequency divider / PWM generator.
- Each channel produces a periodic output of runtime-programmable period and high time, plus an end-of-period tick.
- Configuration is loaded through a valid/ready port into per-channel shadow registers and takes effect only at a period boundary, so no glitched or truncated periods occur.
- Sits between the system clock and downstream blocks that need slow enables, divided clocks or duty-cycled strobes.

---
 rtl/pwm_divider_multi_if.sv | 41 ++++
 rtl/pwm_divider_multi.sv | 130 +++++++++++++
 tb/tb_pwm_divider_multi.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_divider_multi_if.sv
// Configuration port of pwm_divider_multi.
//
// Handshake: a write transfers on a rising clk edge where cfg_valid and
// cfg_ready are both high. The master holds cfg_ch/cfg_period/cfg_on stable
// while cfg_valid is high and not yet accepted. cfg_ready is a combinational
// function of cfg_ch, so it may change in the same cycle cfg_ch changes.
//
// Signals:
//   cfg_valid   master -> slave  write request
//   cfg_ready   slave -> master  selected channel can take a write
//   cfg_ch      master -> slave  target channel
//   cfg_period  master -> slave  new period, cycles
//   cfg_on      master -> slave  new on-time, cycles
interface pwm_divider_multi_if #(
  parameter int CH    = 4,
  parameter int CNT_W = 8
);
  localparam int CH_W = (CH > 1) ? $clog2(CH) : 1;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_period;
  logic [CNT_W-1:0] cfg_on;

  modport master (
    output cfg_valid,
    output cfg_ch,
    output cfg_period,
    output cfg_on,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_ch,
    input  cfg_period,
    input  cfg_on,
    output cfg_ready
  );
endinterface

// File: rtl/pwm_divider_multi.sv
// Multi-channel programmable divider / PWM generator.
//
// Each channel counts 0..P-1 and drives out = (cnt < H) plus a one-cycle
// period_tick in the last cycle of the period. New P/H values are written into
// a per-channel shadow through the cfg port and only become active at a
// period boundary (or immediately when the channel is disabled or halted), so
// periods are never truncated.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   en[CH]       per-channel run enable
//   cfg          configuration write port (slave modport)
//   out[CH]      registered PWM / divided outputs
//   period_tick  registered end-of-period pulse per channel
module pwm_divider_multi #(
  parameter int CH             = 4,
  parameter int CNT_W          = 8,
  parameter int DEFAULT_PERIOD = 6,
  parameter int DEFAULT_ON     = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CH-1:0]            en,
  pwm_divider_multi_if.slave       cfg,
  output logic [CH-1:0]            out,
  output logic [CH-1:0]            period_tick
);

  localparam int CH_W  = (CH > 1) ? $clog2(CH) : 1;
  // Channel-select space; codes at or above CH map onto always-clear slots.
  localparam int SEL_N = 1 << CH_W;

  // Active state. run_q marks a cycle in which cnt_q is a live count; it is
  // low after reset, while disabled and while halted, so the first enabled
  // edge starts a fresh period at cnt=0 instead of counting on from 0.
  logic [CNT_W-1:0] cnt_q   [CH];
  logic [CNT_W-1:0] per_q   [CH];
  logic [CNT_W-1:0] on_q    [CH];
  logic [CNT_W-1:0] per_s_q [CH];
  logic [CNT_W-1:0] on_s_q  [CH];
  logic [CH-1:0]    pend_q;
  logic [CH-1:0]    run_q;

  logic [CNT_W-1:0] cnt_d   [CH];
  logic [CNT_W-1:0] per_d   [CH];
  logic [CNT_W-1:0] on_d    [CH];
  logic [CNT_W-1:0] per_s_d [CH];
  logic [CNT_W-1:0] on_s_d  [CH];
  logic [CH-1:0]    pend_d;
  logic [CH-1:0]    run_d;
  logic [CH-1:0]    out_d;
  logic [CH-1:0]    tick_d;

  logic [CH-1:0]    wr_hit;
  logic [CH-1:0]    wrap;
  logic [CH-1:0]    apply;

  logic [SEL_N-1:0] pend_sel;
  logic             take;

  // Out-of-range channel codes see a zero pend bit, so they are accepted and
  // then match no channel in the write decode below.
  assign pend_sel      = SEL_N'(pend_q);
  assign cfg.cfg_ready = ~pend_sel[cfg.cfg_ch];
  assign take          = cfg.cfg_valid & cfg.cfg_ready;

  always_comb begin
    for (int i = 0; i < CH; i++) begin
      wr_hit[i] = take && (cfg.cfg_ch == CH_W'(i));
      // run_q implies per_q != 0, so per_q-1 cannot underflow when used.
      wrap[i]   = run_q[i] && (cnt_q[i] == per_q[i] - 1'b1);
      // A pending config lands at the wrap edge, or at any edge where the
      // channel is not counting. A write accepted on this edge sets pend for
      // later; it never applies on the edge that accepts it.
      apply[i]  = pend_q[i] && (!en[i] || !run_q[i] || wrap[i]);

      per_d[i]  = apply[i] ? per_s_q[i] : per_q[i];
      on_d[i]   = apply[i] ? on_s_q[i]  : on_q[i];
      pend_d[i] = (pend_q[i] && !apply[i]) || wr_hit[i];

      per_s_d[i] = wr_hit[i] ? cfg.cfg_period : per_s_q[i];
      on_s_d[i]  = wr_hit[i] ? cfg.cfg_on     : on_s_q[i];

      if (!en[i] || (per_d[i] == '0)) begin
        cnt_d[i] = '0;
        run_d[i] = 1'b0;
      end else if (!run_q[i] || wrap[i]) begin
        cnt_d[i] = '0;
        run_d[i] = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
        run_d[i] = 1'b1;
      end

      // Outputs are registered but describe the cycle the new count lives in.
      out_d[i]  = run_d[i] && (cnt_d[i] < on_d[i]);
      tick_d[i] = run_d[i] && (cnt_d[i] == per_d[i] - 1'b1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CH; i++) begin
        cnt_q[i]   <= '0;
        per_q[i]   <= CNT_W'(DEFAULT_PERIOD);
        on_q[i]    <= CNT_W'(DEFAULT_ON);
        per_s_q[i] <= CNT_W'(DEFAULT_PERIOD);
        on_s_q[i]  <= CNT_W'(DEFAULT_ON);
      end
      pend_q      <= '0;
      run_q       <= '0;
      out         <= '0;
      period_tick <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        cnt_q[i]   <= cnt_d[i];
        per_q[i]   <= per_d[i];
        on_q[i]    <= on_d[i];
        per_s_q[i] <= per_s_d[i];
        on_s_q[i]  <= on_s_d[i];
      end
      pend_q      <= pend_d;
      run_q       <= run_d;
      out         <= out_d;
      period_tick <= tick_d;
    end
  end

endmodule

// File: tb/tb_pwm_divider_multi.sv
// Testbench for pwm_divider_multi: a 4-channel instance covering the main
// behaviour and a 5-channel instance used to address channel code 5, which
// lies outside its channel range.
module tb_pwm_divider_multi;

  logic       clk;
  logic       reset;
  logic [3:0] en4;
  logic [3:0] out4;
  logic [3:0] tick4;
  logic [4:0] en5;
  logic [4:0] out5;
  logic [4:0] tick5;

  pwm_divider_multi_if #(.CH(4), .CNT_W(8)) if4 ();
  pwm_divider_multi_if #(.CH(5), .CNT_W(8)) if5 ();

  pwm_divider_multi #(.CH(4), .CNT_W(8), .DEFAULT_PERIOD(6), .DEFAULT_ON(3)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en4),
    .cfg         (if4),
    .out         (out4),
    .period_tick (tick4)
  );

  pwm_divider_multi #(.CH(5), .CNT_W(8), .DEFAULT_PERIOD(6), .DEFAULT_ON(3)) u_dut5 (
    .clk         (clk),
    .reset       (reset),
    .en          (en5),
    .cfg         (if5),
    .out         (out5),
    .period_tick (tick5)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  // Vector layout: {ready5, tick5[1:0], out5[1:0], ready4, tick4[3:0], out4[3:0]}
  logic [13:0] exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          done   = 1'b0;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [13:0] ev;
      logic [13:0] act;
      string       nm;
      ev  = exp_q.pop_front();
      nm  = name_q.pop_front();
      act = {if5.cfg_ready, tick5[1:0], out5[1:0], if4.cfg_ready, tick4, out4};
      checks++;
      if (act !== ev) begin
        errors++;
        $display("FAIL %s: got %h want %h (t=%0t)", nm, act, ev, $time);
      end
    end
  end

  task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, want, $time);
    end
  endtask

  // ---------------- driver ----------------
  function automatic logic [13:0] ev1(input int c, input logic o, input logic t, input logic r);
    logic [13:0] v;
    v = '0;
    v[13] = 1'b1;
    v[8] = r;
    v[4+c] = t;
    v[c] = o;
    return v;
  endfunction

  function automatic logic bit_of(input string s, input int k);
    return s[k] == 8'h31;
  endfunction

  task automatic step(input logic [3:0] e, input logic v, input logic [1:0] ch,
                      input logic [7:0] p, input logic [7:0] h, input logic use5,
                      input logic [13:0] ev, input string nm);
    @(posedge clk);
    #1;
    en4            = e;
    if4.cfg_valid  = v;
    if4.cfg_ch     = ch;
    if4.cfg_period = p;
    if4.cfg_on     = h;
    en5            = use5 ? 5'b00011 : 5'b00000;
    if5.cfg_valid  = use5;
    if5.cfg_ch     = use5 ? 3'd5 : 3'd0;
    if5.cfg_period = 8'd2;
    if5.cfg_on     = 8'd1;
    exp_q.push_back(ev);
    name_q.push_back(nm);
  endtask

  // One step per character; o/t give channel c of the 4-channel DUT (c<0:
  // all its outputs low), r its cfg_ready. With use5 the o/t pattern is
  // expected on channels 0 and 1 of the 5-channel DUT instead.
  task automatic seq(input logic [3:0] e, input logic v, input logic [1:0] ch,
                     input logic [7:0] p, input logic [7:0] h, input int c,
                     input string o, input string t, input string r,
                     input logic use5, input string nm);
    for (int k = 0; k < o.len(); k++) begin
      logic [13:0] ev;
      ev = '0;
      ev[13] = 1'b1;
      ev[8] = bit_of(r, k);
      if (c >= 0) begin
        ev[4+c] = bit_of(t, k);
        ev[c]   = bit_of(o, k);
      end
      if (use5) begin
        ev[12:11] = {2{bit_of(t, k)}};
        ev[10:9]  = {2{bit_of(o, k)}};
      end
      step(e, v, ch, p, h, use5, ev, nm);
    end
  endtask

  task automatic idle_inputs();
    en4 = '0; en5 = '0;
    if4.cfg_valid = 1'b0; if4.cfg_ch = '0; if4.cfg_period = '0; if4.cfg_on = '0;
    if5.cfg_valid = 1'b0; if5.cfg_ch = '0; if5.cfg_period = '0; if5.cfg_on = '0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    idle_inputs();

    // Default config on ch0, plus reset state in the first cycle.
    do_reset();
    seq(4'b0001, 0, 2'd0, 8'd0, 8'd0, 0, "0111000111000111000",
        "0000001000001000001", "1111111111111111111", 0, "default");

    // Write P=4,H=1 while cnt=2; current period completes unchanged.
    seq(4'b0001, 0, 2'd0, 8'd0, 8'd0, 0, "11", "00", "11", 0, "pre_write");
    step(4'b0001, 1, 2'd0, 8'd4, 8'd1, 0, ev1(0, 1, 0, 1), "write_cnt2");
    seq(4'b0001, 0, 2'd0, 8'd0, 8'd0, 0, "00010001000", "00100010001",
        "00011111111", 0, "p4h1");

    // Boundary values on ch1.
    do_reset();
    step(4'b0000, 1, 2'd1, 8'd6, 8'd0, 0, ev1(1, 0, 0, 1), "wr_h0");
    seq(4'b0010, 0, 2'd1, 8'd0, 8'd0, 1, "0000000000000", "0000001000001",
        "0111111111111", 0, "h0");
    step(4'b0010, 1, 2'd1, 8'd5, 8'd9, 0, ev1(1, 0, 0, 1), "wr_h9");
    seq(4'b0010, 0, 2'd1, 8'd0, 8'd0, 1, "000001111111111", "000010000100001",
        "000001111111111", 0, "h9p5");
    step(4'b0010, 1, 2'd1, 8'd1, 8'd1, 0, ev1(1, 1, 0, 1), "wr_p1");
    seq(4'b0010, 0, 2'd1, 8'd0, 8'd0, 1, "11111111", "00011111", "00001111", 0, "p1");
    step(4'b0010, 1, 2'd1, 8'd0, 8'd0, 0, ev1(1, 1, 1, 1), "wr_p0_in_wrap");
    seq(4'b0010, 0, 2'd1, 8'd0, 8'd0, 1, "10000", "10000", "01111", 0, "p0_halt");
    step(4'b0010, 1, 2'd1, 8'd3, 8'd2, 0, ev1(1, 0, 0, 1), "wr_from_halt");
    seq(4'b0010, 0, 2'd1, 8'd0, 8'd0, 1, "0110110", "0001001", "0111111", 0, "halt_restart");

    // Enable toggle on ch2 with a config written while disabled.
    do_reset();
    seq(4'b0100, 0, 2'd2, 8'd0, 8'd0, 2, "01110001110", "00000010000",
        "11111111111", 0, "ch2_run");
    step(4'b0000, 0, 2'd2, 8'd0, 8'd0, 0, ev1(2, 0, 0, 1), "en_low_cnt4");
    step(4'b0000, 1, 2'd2, 8'd4, 8'd2, 0, ev1(2, 0, 0, 1), "wr_disabled");
    step(4'b0000, 0, 2'd2, 8'd0, 8'd0, 0, ev1(2, 0, 0, 0), "disabled_pend");
    step(4'b0100, 0, 2'd2, 8'd0, 8'd0, 0, ev1(2, 0, 0, 1), "applied_off");
    seq(4'b0100, 0, 2'd2, 8'd0, 8'd0, 2, "11001100", "00010001", "11111111", 0, "en_restart");

    // Back-to-back writes to ch3: second stalls until the first applies.
    do_reset();
    seq(4'b1000, 0, 2'd3, 8'd0, 8'd0, 3, "0", "0", "1", 0, "ch3_start");
    step(4'b1000, 1, 2'd3, 8'd2, 8'd1, 0, ev1(3, 1, 0, 1), "wr_first");
    seq(4'b1000, 1, 2'd3, 8'd3, 8'd3, 3, "110001", "000010", "000001", 0, "wr_stall");
    seq(4'b1000, 0, 2'd3, 8'd0, 8'd0, 3, "0111111", "1001001", "0111111", 0, "p3h3");

    // Channel code 5 on a 5-channel instance: accepted, no effect.
    do_reset();
    seq(4'b0000, 0, 2'd0, 8'd0, 8'd0, -1, "0111000111000111000",
        "0000001000001000001", "1111111111111111111", 1, "oor_write");

    // Asynchronous reset mid-period with a pending write.
    do_reset();
    seq(4'b0001, 0, 2'd0, 8'd0, 8'd0, 0, "01", "00", "11", 0, "pre_rst");
    step(4'b0001, 1, 2'd0, 8'd2, 8'd2, 0, ev1(0, 1, 0, 1), "wr_before_rst");
    @(posedge clk);
    #1;
    if4.cfg_valid = 1'b0;
    chk("pre_async", {if4.cfg_ready, tick4, out4}, 9'b0_0000_0001);
    #2;
    reset = 1'b1;
    #1;
    chk("async_clear", {if4.cfg_ready, tick4, out4}, 9'b1_0000_0000);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    seq(4'b0001, 0, 2'd0, 8'd0, 8'd0, 0, "111000111000", "000001000001",
        "111111111111", 0, "post_rst");

    // Drain.
    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    if (!done) begin
      errors++;
      $display("FAIL watchdog: got timeout want completion");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

endmodule
